// File: rtl/csr_file_pkg.sv
// CSR addresses, field positions, exception codes and write masks
// shared by the CSR file and the write-back stage.
package csr_file_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam int CRMD_PLV  = 0;
  localparam int CRMD_IE   = 2;
  localparam int CRMD_DA   = 3;
  localparam int PRMD_PPLV = 0;
  localparam int PRMD_PIE  = 2;
  localparam int ESTAT_ECODE = 16;
  localparam int ESTAT_ESUB  = 22;
  localparam int IS_TI     = 11;
  localparam int IS_IPI    = 12;
  localparam int TCFG_EN   = 0;
  localparam int TCFG_PER  = 1;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

  typedef struct packed {
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  typedef struct packed {
    logic       pie;
    logic [1:0] pplv;
  } prmd_t;

  function automatic logic [31:0] wmerge(
    input logic [31:0] old,
    input logic [31:0] wv,
    input logic [31:0] wm
  );
    return (wv & wm) | (old & ~wm);
  endfunction

endpackage

// File: rtl/csr_file_timer.sv
// Countdown timer: holds TVAL, reloads on TCFG writes or periodic
// expiry, and flags the cycle in which it expires.
module csr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [29:0] load_init,
  input  logic        en,
  input  logic        periodic,
  input  logic [29:0] init,
  output logic [31:0] tval,
  output logic        tick
);

  assign tick = en && (tval == 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tval <= '0;
    end else if (load) begin
      tval <= {load_init, 2'b00};
    end else if (tick) begin
      tval <= periodic ? {init, 2'b00} : '0;
    end else if (en && tval != '0) begin
      tval <= tval - 32'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Control and status register file: privilege state, exception
// bookkeeping, interrupt status and the local timer.
module csr_file
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        eret_flush,
  input  logic [31:0] wb_pc,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);

  crmd_t       crmd;
  prmd_t       prmd;
  logic [12:0] ecfg;
  logic [12:0] est_is;
  logic [5:0]  ecode;
  logic [8:0]  esub;
  logic [31:0] era;
  logic [25:0] eentry;
  logic [31:0] save0, save1, save2, save3;
  logic [31:0] tid;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        tick;

  logic [31:0] wbits;
  logic [31:0] wdata;
  logic        unused_re;

  assign unused_re = csr_re;

  // Read mux also yields the writable-bit mask of the addressed CSR
  always_comb begin
    csr_rvalue = '0;
    wbits      = '0;
    case (csr_num)
      CSR_CRMD: begin
        csr_rvalue = {28'b0, crmd};
        wbits      = CRMD_WMASK;
      end
      CSR_PRMD: begin
        csr_rvalue = {29'b0, prmd};
        wbits      = PRMD_WMASK;
      end
      CSR_ECFG: begin
        csr_rvalue = {19'b0, ecfg};
        wbits      = ECFG_WMASK;
      end
      CSR_ESTAT: begin
        csr_rvalue = {1'b0, esub, ecode, 3'b0, est_is};
        wbits      = ESTAT_WMASK;
      end
      CSR_ERA: begin
        csr_rvalue = era;
        wbits      = '1;
      end
      CSR_EENTRY: begin
        csr_rvalue = {eentry, 6'b0};
        wbits      = EENTRY_WMASK;
      end
      CSR_SAVE0: begin
        csr_rvalue = save0;
        wbits      = '1;
      end
      CSR_SAVE1: begin
        csr_rvalue = save1;
        wbits      = '1;
      end
      CSR_SAVE2: begin
        csr_rvalue = save2;
        wbits      = '1;
      end
      CSR_SAVE3: begin
        csr_rvalue = save3;
        wbits      = '1;
      end
      CSR_TID: begin
        csr_rvalue = tid;
        wbits      = '1;
      end
      CSR_TCFG: begin
        csr_rvalue = tcfg;
        wbits      = '1;
      end
      CSR_TVAL: begin
        csr_rvalue = tval;
      end
      default: begin
        csr_rvalue = '0;
      end
    endcase
  end

  assign wdata = wmerge(csr_rvalue, csr_wvalue, csr_wmask & wbits);

  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat;
  logic wr_era, wr_eentry, wr_tid, wr_tcfg;
  logic wr_save0, wr_save1, wr_save2, wr_save3;
  logic ticlr_clr;

  assign wr_crmd   = csr_we && csr_num == CSR_CRMD;
  assign wr_prmd   = csr_we && csr_num == CSR_PRMD;
  assign wr_ecfg   = csr_we && csr_num == CSR_ECFG;
  assign wr_estat  = csr_we && csr_num == CSR_ESTAT;
  assign wr_era    = csr_we && csr_num == CSR_ERA;
  assign wr_eentry = csr_we && csr_num == CSR_EENTRY;
  assign wr_save0  = csr_we && csr_num == CSR_SAVE0;
  assign wr_save1  = csr_we && csr_num == CSR_SAVE1;
  assign wr_save2  = csr_we && csr_num == CSR_SAVE2;
  assign wr_save3  = csr_we && csr_num == CSR_SAVE3;
  assign wr_tid    = csr_we && csr_num == CSR_TID;
  assign wr_tcfg   = csr_we && csr_num == CSR_TCFG;
  assign ticlr_clr = csr_we && csr_num == CSR_TICLR
                  && csr_wvalue[0] && csr_wmask[0];

  // Later assignments override: exception beats ertn beats a CSR write
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd <= '{da: 1'b1, ie: 1'b0, plv: 2'b00};
    end else begin
      if (wr_crmd) crmd <= crmd_t'(wdata[3:0]);
      if (wb_ex) begin
        crmd.plv <= 2'b00;
        crmd.ie  <= 1'b0;
      end else if (eret_flush) begin
        crmd.plv <= prmd.pplv;
        crmd.ie  <= prmd.pie;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prmd <= '0;
    end else if (wb_ex) begin
      prmd.pplv <= crmd.plv;
      prmd.pie  <= crmd.ie;
    end else if (wr_prmd) begin
      prmd <= prmd_t'(wdata[2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ecfg <= '0;
    end else if (wr_ecfg) begin
      ecfg <= wdata[12:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      est_is <= '0;
      ecode  <= '0;
      esub   <= '0;
    end else begin
      if (wr_estat) est_is[1:0] <= wdata[1:0];
      est_is[9:2]   <= hw_int_in;
      est_is[10]    <= 1'b0;
      est_is[IS_IPI] <= ipi_int_in;
      if (tick) est_is[IS_TI] <= 1'b1;
      else if (ticlr_clr) est_is[IS_TI] <= 1'b0;
      if (wb_ex) begin
        ecode <= wb_ecode;
        esub  <= wb_esubcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      era    <= '0;
      eentry <= '0;
      tid    <= '0;
      tcfg   <= '0;
    end else begin
      if (wb_ex) era <= wb_pc;
      else if (wr_era) era <= wdata;
      if (wr_eentry) eentry <= wdata[31:6];
      if (wr_tid) tid <= wdata;
      if (wr_tcfg) tcfg <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      save0 <= '0;
      save1 <= '0;
      save2 <= '0;
      save3 <= '0;
    end else begin
      if (wr_save0) save0 <= wdata;
      if (wr_save1) save1 <= wdata;
      if (wr_save2) save2 <= wdata;
      if (wr_save3) save3 <= wdata;
    end
  end

  csr_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_tcfg),
    .load_init (wdata[31:2]),
    .en        (tcfg[TCFG_EN]),
    .periodic  (tcfg[TCFG_PER]),
    .init      (tcfg[31:2]),
    .tval      (tval),
    .tick      (tick)
  );

  assign ex_entry = {eentry, 6'b0};
  assign era_pc   = era;
  assign has_int  = crmd.ie && |(est_is & ecfg);

endmodule

// File: tb/tb_csr_file.sv
// Directed-vector bench for csr_file with a queue-based scoreboard.
module tb_csr_file;
  import csr_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        eret_flush;
  logic [31:0] wb_pc;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic        has_int;

  csr_file dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .eret_flush  (eret_flush),
    .wb_pc       (wb_pc),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .era_pc      (era_pc),
    .has_int     (has_int)
  );

  always #5 clk = ~clk;

  // sel: 0 rvalue, 1 era_pc, 2 ex_entry, 3 has_int
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t e;
      logic [31:0] act;
      e = sbq.pop_front();
      case (e.sel)
        1:       act = era_pc;
        2:       act = ex_entry;
        3:       act = {31'b0, has_int};
        default: act = csr_rvalue;
      endcase
      act = act & e.mask;
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h",
                    e.name, act, e.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m,
                    input logic [31:0] v);
    csr_num    = a;
    csr_wmask  = m;
    csr_wvalue = v;
    csr_we     = 1'b1;
    step(1);
    csr_we = 1'b0;
  endtask

  task automatic chk(input string nm, input int sel,
                     input logic [13:0] a, input logic [31:0] m,
                     input logic [31:0] x);
    sb_t e;
    e.name = nm;
    e.sel  = sel;
    e.mask = m;
    e.exp  = x;
    csr_num = a;
    sbq.push_back(e);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    csr_re      = 1'b1;
    csr_num     = CSR_CRMD;
    csr_we      = 1'b1;
    csr_wmask   = '1;
    csr_wvalue  = 32'h7;
    wb_ex       = 1'b1;
    wb_ecode    = 6'h3F;
    wb_esubcode = 9'h1FF;
    eret_flush  = 1'b0;
    wb_pc       = 32'hFFFF_FFFF;
    hw_int_in   = 8'h00;
    ipi_int_in  = 1'b0;
    step(2);
    reset  = 1'b0;
    csr_we = 1'b0;
    wb_ex  = 1'b0;

    chk("rst_crmd", 0, CSR_CRMD, '1, 32'h8);
    chk("rd_unimpl", 0, 14'h07, '1, 32'h0);
    chk("rst_hasint", 3, CSR_CRMD, '1, 32'h0);
    chk("rst_era", 1, CSR_CRMD, '1, 32'h0);
    chk("rst_estat", 0, CSR_ESTAT, '1, 32'h0);
    chk("rst_prmd", 0, CSR_PRMD, '1, 32'h0);

    wr(CSR_SAVE1, '1, 32'h1234_5678);
    wr(CSR_SAVE1, 32'hFFFF_0000, 32'hDEAD_BEEF);
    chk("save1_mask", 0, CSR_SAVE1, '1, 32'hDEAD_5678);

    wr(CSR_ECFG, '1, '1);
    chk("ecfg_bits", 0, CSR_ECFG, '1, 32'h0000_1BFF);
    wr(CSR_EENTRY, '1, '1);
    chk("ex_entry", 2, CSR_EENTRY, '1, 32'hFFFF_FFC0);
    chk("ticlr_rd0", 0, CSR_TICLR, '1, 32'h0);

    wr(CSR_CRMD, 32'h7, 32'h7);
    chk("crmd_7", 0, CSR_CRMD, '1, 32'hF);
    wb_ex       = 1'b1;
    wb_ecode    = ECODE_SYS;
    wb_esubcode = 9'h0;
    wb_pc       = 32'h1C00_0100;
    step(1);
    wb_ex = 1'b0;
    chk("ex_crmd", 0, CSR_CRMD, 32'h7, 32'h0);
    chk("ex_prmd", 0, CSR_PRMD, 32'h7, 32'h7);
    chk("ex_ecode", 0, CSR_ESTAT, 32'h003F_0000, 32'h000B_0000);
    chk("ex_era", 1, CSR_CRMD, '1, 32'h1C00_0100);
    eret_flush = 1'b1;
    step(1);
    eret_flush = 1'b0;
    chk("eret_crmd", 0, CSR_CRMD, 32'h7, 32'h7);

    // exception and CRMD write together: DA still taken from the write
    wb_ex       = 1'b1;
    wb_ecode    = ECODE_ADE;
    wb_esubcode = 9'h1;
    wb_pc       = 32'h1C00_0200;
    wr(CSR_CRMD, '1, 32'h3);
    wb_ex = 1'b0;
    chk("exwe_crmd", 0, CSR_CRMD, '1, 32'h0);
    chk("exwe_prmd", 0, CSR_PRMD, '1, 32'h7);

    wr(CSR_CRMD, '1, 32'h4);
    wr(CSR_ESTAT, '1, '1);
    chk("estat_wr", 0, CSR_ESTAT, '1, 32'h0048_0003);
    chk("swint_has", 3, CSR_CRMD, '1, 32'h1);
    wr(CSR_ESTAT, 32'h3, 32'h0);
    chk("swint_clr", 3, CSR_CRMD, '1, 32'h0);

    hw_int_in = 8'h5A;
    step(1);
    chk("hwint_is", 0, CSR_ESTAT, 32'h0000_03FC, 32'h0000_0168);
    chk("hwint_has", 3, CSR_CRMD, '1, 32'h1);
    hw_int_in = 8'h00;
    step(1);

    wr(CSR_ECFG, '1, 32'h0000_0800);
    wr(CSR_TCFG, '1, 32'h0000_000B);
    for (int v = 8; v >= 2; v--)
      chk("tval_seq", 0, CSR_TVAL, '1, 32'(v));
    chk("ti_before", 0, CSR_ESTAT, 32'h800, 32'h0);
    chk("tval_reload", 0, CSR_TVAL, '1, 32'h8);
    chk("ti_set", 0, CSR_ESTAT, 32'h800, 32'h800);
    chk("ti_has", 3, CSR_CRMD, '1, 32'h1);
    wr(CSR_TICLR, 32'h1, 32'h1);
    chk("ticlr_is", 0, CSR_ESTAT, 32'h800, 32'h0);
    chk("ticlr_has", 3, CSR_CRMD, '1, 32'h0);
    chk("tval_run", 0, CSR_TVAL, '1, 32'h2);

    wr(CSR_TCFG, '1, 32'h0);
    wr(CSR_TICLR, 32'h1, 32'h1);
    wr(CSR_TCFG, '1, 32'h0000_0009);
    step(12);
    chk("oneshot_ti", 0, CSR_ESTAT, 32'h800, 32'h800);
    chk("oneshot_tv", 0, CSR_TVAL, '1, 32'h0);
    wr(CSR_TICLR, 32'h1, 32'h1);
    step(10);
    chk("oneshot_no2", 0, CSR_ESTAT, 32'h800, 32'h0);
    chk("oneshot_hold", 0, CSR_TVAL, '1, 32'h0);

    step(2);
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
